// File: rtl/regfile_writeback.sv
// Write-back sequencer for the 32 x 32 register file: merges single-cycle ALU results
// with FIFO-buffered memory results into at most one register-file write per clock.
module regfile_writeback #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid_i,
    input  logic [4:0]              alu_addr_i,
    input  logic [31:0]             alu_data_i,
    output logic                    alu_ready_o,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic [4:0]              mem_addr_i,
    input  logic [31:0]             mem_data_i,
    output logic [4:0]              wr_addr_o,
    output logic [31:0]             wr_data_o,
    output logic                    reg_write_o,
    output logic [31:0]             pending_o,
    output logic [$clog2(DEPTH):0]  fifo_count_o
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {NORMAL, THROTTLE} state_t;

    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [7:0]    starve_q, starve_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          fifo_empty, alu_win, fifo_pop, fifo_push;
    logic [31:0]   pending_v;

    assign fifo_empty  = (count_q == '0);
    assign alu_ready_o = (state_q == NORMAL);
    assign mem_ready_o = (count_q < FULL_C) && rst_n;
    assign alu_win     = alu_valid_i && alu_ready_o && (alu_addr_i != 5'd0);
    // The pop decision uses the registered count, so an entry pushed this cycle cannot pop.
    assign fifo_pop    = !alu_win && !fifo_empty;
    assign fifo_push   = mem_valid_i && mem_ready_o && (mem_addr_i != 5'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        reg_write_d = alu_win || fifo_pop;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (alu_win) begin
            wr_addr_d = alu_addr_i;
            wr_data_d = alu_data_i;
        end else if (fifo_pop) begin
            wr_addr_d = fifo_q[rd_ptr_q].addr;
            wr_data_d = fifo_q[rd_ptr_q].data;
        end
        rd_ptr_d = fifo_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = fifo_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(fifo_push) - CW'(fifo_pop);
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            NORMAL: begin
                if (fifo_pop || fifo_empty) begin
                    starve_d = '0;
                end else if (alu_win) begin
                    starve_d = starve_q + 8'd1;
                    if (starve_d == LIMIT_C) state_d = THROTTLE;
                end
            end
            THROTTLE: begin
                starve_d = '0;
                state_d  = NORMAL;
            end
            default: begin
                starve_d = '0;
                state_d  = NORMAL;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= NORMAL;
            starve_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // NOTE: FIFO storage has no reset; count_q alone decides which slots hold live entries.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_q[wr_ptr_q] <= '{addr: mem_addr_i, data: mem_data_i};
    end

    always_comb begin
        pending_v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) pending_v[fifo_q[rd_ptr_q + PW'(i)].addr] = 1'b1;
        end
        if (reg_write_q) pending_v[wr_addr_q] = 1'b1;
        pending_v[0] = 1'b0;
    end

    assign pending_o    = pending_v;
    assign reg_write_o  = reg_write_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: vector table plus reset and starvation sequences,
// with a write scoreboard fed from a small model of the memory FIFO.
module tb_regfile_writeback;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   alu_valid_i;
    logic [4:0]             alu_addr_i;
    logic [31:0]            alu_data_i;
    logic                   alu_ready_o;
    logic                   mem_valid_i;
    logic                   mem_ready_o;
    logic [4:0]             mem_addr_i;
    logic [31:0]            mem_data_i;
    logic [4:0]             wr_addr_o;
    logic [31:0]            wr_data_o;
    logic                   reg_write_o;
    logic [31:0]            pending_o;
    logic [$clog2(DEPTH):0] fifo_count_o;

    regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid_i  (alu_valid_i),
        .alu_addr_i   (alu_addr_i),
        .alu_data_i   (alu_data_i),
        .alu_ready_o  (alu_ready_o),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .reg_write_o  (reg_write_o),
        .pending_o    (pending_o),
        .fifo_count_o (fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        int          cnt;
        logic        mrdy;
    } vec_t;

    wr_t        exp_q[$];
    wr_t        model_q[$];
    logic       exp_out_valid;
    logic [4:0] exp_out_addr;
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (model_q[i]) p[model_q[i].addr] = 1'b1;
        if (exp_out_valid) p[exp_out_addr] = 1'b1;
        return p;
    endfunction

    task automatic scoreboard();
        wr_t w;
        if (exp_q.size() > 0) begin
            w             = exp_q.pop_front();
            exp_out_valid = 1'b1;
            exp_out_addr  = w.addr;
            check("sb_write", {reg_write_o, wr_addr_o, wr_data_o}, {1'b1, w.addr, w.data});
        end else begin
            exp_out_valid = 1'b0;
            check("sb_idle", 64'(reg_write_o), 64'd0);
        end
        check("sb_fifo_count", 64'(fifo_count_o), 64'(model_q.size()));
        check("sb_pending", 64'(pending_o), 64'(model_pending()));
    endtask

    // Called just after a rising edge; drives one cycle of stimulus and checks after the next edge.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        wr_t w;
        alu_valid_i = av && alu_ready_o;
        alu_addr_i  = aa;
        alu_data_i  = ad;
        mem_valid_i = mv;
        mem_addr_i  = ma;
        mem_data_i  = md;
        if (alu_valid_i && aa != 5'd0) begin
            w = '{addr: aa, data: ad};
            exp_q.push_back(w);
        end else if (model_q.size() > 0) begin
            exp_q.push_back(model_q.pop_front());
        end
        if (mv && mem_ready_o && ma != 5'd0) begin
            w = '{addr: ma, data: md};
            model_q.push_back(w);
        end
        @(posedge clk);
        #1;
        scoreboard();
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n       = 1'b0;
        alu_valid_i = 1'b0;
        mem_valid_i = 1'b0;
        #1;
        check("mem_ready_during_reset", 64'(mem_ready_o), 64'd0);
        repeat (n) @(posedge clk);
        #1;
        model_q.delete();
        exp_q.delete();
        exp_out_valid = 1'b0;
        check("rst_outputs", {reg_write_o, wr_addr_o, wr_data_o}, 64'd0);
        check("rst_fifo_count", 64'(fifo_count_o), 64'd0);
        check("rst_pending", 64'(pending_o), 64'd0);
        check("rst_alu_ready", 64'(alu_ready_o), 64'd1);
        check("rst_mem_ready_held", 64'(mem_ready_o), 64'd0);
        rst_n = 1'b1;
        #1;
        check("mem_ready_after_reset", 64'(mem_ready_o), 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && alu_valid_i && !alu_ready_o) begin
            checks++;
            failures++;
            $display("FAIL alu_protocol: alu_valid=1 while alu_ready=0 at %0t", $time);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        vec_t vecs[20];
        rst_n         = 1'b1;
        alu_valid_i   = 1'b0;
        alu_addr_i    = '0;
        alu_data_i    = '0;
        mem_valid_i   = 1'b0;
        mem_addr_i    = '0;
        mem_data_i    = '0;
        exp_out_valid = 1'b0;
        exp_out_addr  = '0;

        //          av  aa   ad            mv  ma  md            rw  wa  wd            cnt mrdy
        vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0, 32'h0,        1, 5,  32'hDEADBEEF, 0, 1};
        vecs[1]  = '{0, 0,  32'h0,        0, 0, 32'h0,        0, 5,  32'hDEADBEEF, 0, 1};
        vecs[2]  = '{1, 10, 32'h00000A10, 1, 1, 32'h00000101, 1, 10, 32'h00000A10, 1, 1};
        vecs[3]  = '{1, 11, 32'h00000A11, 1, 2, 32'h00000102, 1, 11, 32'h00000A11, 2, 1};
        vecs[4]  = '{1, 12, 32'h00000A12, 1, 3, 32'h00000103, 1, 12, 32'h00000A12, 3, 1};
        vecs[5]  = '{1, 13, 32'h00000A13, 1, 4, 32'h00000104, 1, 13, 32'h00000A13, 4, 0};
        vecs[6]  = '{1, 14, 32'h00000A14, 1, 6, 32'h00000106, 1, 14, 32'h00000A14, 4, 0};
        vecs[7]  = '{0, 0,  32'h0,        1, 6, 32'h00000106, 1, 1,  32'h00000101, 3, 1};
        vecs[8]  = '{0, 0,  32'h0,        1, 6, 32'h00000106, 1, 2,  32'h00000102, 3, 1};
        vecs[9]  = '{0, 0,  32'h0,        0, 0, 32'h0,        1, 3,  32'h00000103, 2, 1};
        vecs[10] = '{0, 0,  32'h0,        0, 0, 32'h0,        1, 4,  32'h00000104, 1, 1};
        vecs[11] = '{0, 0,  32'h0,        0, 0, 32'h0,        1, 6,  32'h00000106, 0, 1};
        vecs[12] = '{0, 0,  32'h0,        0, 0, 32'h0,        0, 6,  32'h00000106, 0, 1};
        vecs[13] = '{1, 9,  32'h00000A09, 1, 7, 32'h00000107, 1, 9,  32'h00000A09, 1, 1};
        vecs[14] = '{0, 0,  32'h0,        0, 0, 32'h0,        1, 7,  32'h00000107, 0, 1};
        vecs[15] = '{0, 0,  32'h0,        0, 0, 32'h0,        0, 7,  32'h00000107, 0, 1};
        vecs[16] = '{1, 0,  32'h0000BAD0, 1, 0, 32'h0000BAD1, 0, 7,  32'h00000107, 0, 1};
        vecs[17] = '{1, 0,  32'h0000BAD2, 1, 8, 32'h00000108, 0, 7,  32'h00000107, 1, 1};
        vecs[18] = '{1, 0,  32'h0000BAD3, 0, 0, 32'h0,        1, 8,  32'h00000108, 0, 1};
        vecs[19] = '{0, 0,  32'h0,        0, 0, 32'h0,        0, 8,  32'h00000108, 0, 1};

        @(posedge clk);
        #1;
        do_reset(2);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
            check($sformatf("vec%0d_write", i), {reg_write_o, wr_addr_o, wr_data_o},
                  {vecs[i].rw, vecs[i].wa, vecs[i].wd});
            check($sformatf("vec%0d_count", i), 64'(fifo_count_o), 64'(vecs[i].cnt));
            check($sformatf("vec%0d_mem_ready", i), 64'(mem_ready_o), 64'(vecs[i].mrdy));
        end

        // Reset with three entries queued: everything queued is discarded.
        step(1'b1, 5'd10, 32'h1010, 1'b1, 5'd1, 32'h2001);
        step(1'b1, 5'd11, 32'h1011, 1'b1, 5'd2, 32'h2002);
        step(1'b1, 5'd12, 32'h1012, 1'b1, 5'd3, 32'h2003);
        check("pre_reset_count", 64'(fifo_count_o), 64'd3);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            idle();
            check($sformatf("post_reset_quiet%0d", i), {reg_write_o, fifo_count_o}, 64'd0);
        end

        // One queued entry starved by a continuous ALU stream until the throttle cycle.
        step(1'b1, 5'd21, 32'h3000, 1'b1, 5'd20, 32'h4020);
        check("starve_ready0", 64'(alu_ready_o), 64'd1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 5'(21 + k), 32'h3000 + 32'(k), 1'b0, 5'd0, 32'd0);
            check($sformatf("starve_ready%0d", k), 64'(alu_ready_o), 64'((k == STARVE_LIMIT) ? 0 : 1));
            if (k == STARVE_LIMIT + 1)
                check("starve_fifo_write", {reg_write_o, wr_addr_o, wr_data_o}, {1'b1, 5'd20, 32'h4020});
        end
        idle();
        check("end_empty", 64'(fifo_count_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
